// File: rtl/cov_accum_pkg.sv
// Shared constants and FSM encoding for the covariance accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cov_accum_pkg;

    localparam int DEF_N_SAMPLES = 128;   // samples per covariance frame
    localparam int DEF_LOG2N     = 7;     // log2(DEF_N_SAMPLES), the divide shift
    localparam int DEF_DW        = 16;    // product / covariance width
    localparam int N_LANES       = 10;    // upper-triangle entries of a 4x4 matrix

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cov_acc_lane.sv
// One signed accumulator with synchronous clear, add enable and a /N (shift) view.
// Latency: accumulate 1 cycle; o_shift is combinational from the accumulator.
// Backpressure: none; i_add_en qualifies each product.
module cov_acc_lane
    import cov_accum_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_add_en,
    input  logic signed [DW-1:0] i_prod,
    output logic signed [DW-1:0] o_shift
);

    // Headroom of LOG2N bits lets N_SAMPLES full-scale products sum without wrap.
    localparam int ACW = DW + LOG2N;

    logic signed [ACW-1:0] r_acc;

    // Accumulator: clear has priority over add; products are sign-extended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= r_acc + ACW'(i_prod);
        end
    end

    // Arithmetic shift floors toward -inf; the mean always fits in DW bits.
    assign o_shift = DW'(r_acc >>> LOG2N);

endmodule

// File: rtl/cov_accum.sv
// Averages ten product streams over a frame of N_SAMPLES into covariance estimates.
// Latency: cov_valid rises 2 cycles after the cycle accepting the last sample.
// Backpressure: none; samples are taken on in_valid while accumulating, else ignored.
module cov_accum
    import cov_accum_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int LOG2N     = DEF_LOG2N,
    parameter int DW        = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] X1X1,
    input  logic signed [DW-1:0] X1X2,
    input  logic signed [DW-1:0] X1X3,
    input  logic signed [DW-1:0] X1X4,
    input  logic signed [DW-1:0] X2X2,
    input  logic signed [DW-1:0] X2X3,
    input  logic signed [DW-1:0] X2X4,
    input  logic signed [DW-1:0] X3X3,
    input  logic signed [DW-1:0] X3X4,
    input  logic signed [DW-1:0] X4X4,
    output logic signed [DW-1:0] C11,
    output logic signed [DW-1:0] C12,
    output logic signed [DW-1:0] C13,
    output logic signed [DW-1:0] C14,
    output logic signed [DW-1:0] C22,
    output logic signed [DW-1:0] C23,
    output logic signed [DW-1:0] C24,
    output logic signed [DW-1:0] C33,
    output logic signed [DW-1:0] C34,
    output logic signed [DW-1:0] C44,
    output logic                 busy,
    output logic                 cov_valid
);

    // One extra counter bit so the count can reach N_SAMPLES itself.
    localparam int CW = LOG2N + 1;

    state_t                r_state;
    state_t                w_next;
    logic                  w_clr;
    logic                  w_add_en;
    logic                  w_load;
    logic [CW-1:0]         r_cnt;
    logic                  r_cov_valid;
    logic signed [DW-1:0]  w_prod [N_LANES];
    logic signed [DW-1:0]  w_mean [N_LANES];
    logic signed [DW-1:0]  r_c    [N_LANES];

    assign w_prod[0] = X1X1;
    assign w_prod[1] = X1X2;
    assign w_prod[2] = X1X3;
    assign w_prod[3] = X1X4;
    assign w_prod[4] = X2X2;
    assign w_prod[5] = X2X3;
    assign w_prod[6] = X2X4;
    assign w_prod[7] = X3X3;
    assign w_prod[8] = X3X4;
    assign w_prod[9] = X4X4;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and lane controls; in_valid only counts while accumulating.
    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_add_en = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    w_add_en = 1'b1;
                    if (r_cnt == CW'(N_SAMPLES - 1)) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_load = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Sample counter, cleared together with the accumulators at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
        end else if (w_add_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_LANES; g++) begin : g_lane
            cov_acc_lane #(
                .DW    (DW),
                .LOG2N (LOG2N)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_clr),
                .i_add_en (w_add_en),
                .i_prod   (w_prod[g]),
                .o_shift  (w_mean[g])
            );
        end
    endgenerate

    // Output registers capture the means in DONE and hold them until the next DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_LANES; k++) begin
                r_c[k] <= '0;
            end
            r_cov_valid <= 1'b0;
        end else begin
            if (w_load) begin
                for (int k = 0; k < N_LANES; k++) begin
                    r_c[k] <= w_mean[k];
                end
            end
            r_cov_valid <= w_load;
        end
    end

    assign C11       = r_c[0];
    assign C12       = r_c[1];
    assign C13       = r_c[2];
    assign C14       = r_c[3];
    assign C22       = r_c[4];
    assign C23       = r_c[5];
    assign C24       = r_c[6];
    assign C33       = r_c[7];
    assign C34       = r_c[8];
    assign C44       = r_c[9];
    assign cov_valid = r_cov_valid;
    assign busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);

endmodule

// File: tb/tb_cov_accum.sv
// Directed, table-driven bench for cov_accum: one frame per table row plus reset sequences.
// Latency: expects cov_valid 2 cycles after the last accepted sample.
// Backpressure: exercises in_valid gaps and ignored start / in_valid pulses.
module tb_cov_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] prod  [10];
    logic signed [15:0] c_out [10];
    logic               busy;
    logic               cov_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cov_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .X1X1      (prod[0]),
        .X1X2      (prod[1]),
        .X1X3      (prod[2]),
        .X1X4      (prod[3]),
        .X2X2      (prod[4]),
        .X2X3      (prod[5]),
        .X2X4      (prod[6]),
        .X3X3      (prod[7]),
        .X3X4      (prod[8]),
        .X4X4      (prod[9]),
        .C11       (c_out[0]),
        .C12       (c_out[1]),
        .C13       (c_out[2]),
        .C14       (c_out[3]),
        .C22       (c_out[4]),
        .C23       (c_out[5]),
        .C24       (c_out[6]),
        .C33       (c_out[7]),
        .C34       (c_out[8]),
        .C44       (c_out[9]),
        .busy      (busy),
        .cov_valid (cov_valid)
    );

    // One frame: which product lane is driven, its value for samples 0..63 and
    // 64..127, whether a 1-cycle gap follows every 10th sample, whether the start
    // cycle also carries in_valid with a junk product, the sample index on which
    // start is re-pulsed (-1 none), and the hand-computed mean for that lane.
    typedef struct {
        string       name;
        int          lane;
        int          va;
        int          vb;
        bit          gap;
        bit          start_with_valid;
        int          start_at;
        int          exp_c;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_prods();
        for (int k = 0; k < 10; k++) prod[k] = '0;
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        bit busy_ok;
        busy_ok = 1'b1;
        // Start cycle, optionally with a junk sample that must be dropped.
        clear_prods();
        start    = 1'b1;
        in_valid = v.start_with_valid;
        if (v.start_with_valid) prod[v.lane] = 16'sd1000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            clear_prods();
            prod[v.lane] = 16'((i < 64) ? v.va : v.vb);
            in_valid = 1'b1;
            start    = (i == v.start_at);
            tick();
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (v.gap && ((i + 1) % 10 == 0) && (i != 127)) begin
                in_valid = 1'b0;
                start    = (v.start_at >= 0);
                tick();
                start = 1'b0;
                if (!busy) busy_ok = 1'b0;
            end
        end
        in_valid = 1'b0;
        clear_prods();
        // Cycle 1 after the accepting cycle is DONE; cov_valid belongs in cycle 2.
        cyc = 1;
        while (!cov_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({v.name, " busy_during_frame"}, int'(busy_ok), 1);
        chk({v.name, " cov_valid_latency"}, cyc, 2);
        chk({v.name, " busy_after_frame"}, int'(busy), 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s C[%0d]", v.name, k), int'(c_out[k]),
                (k == v.lane) ? v.exp_c : 0);
        end
        tick();
        chk({v.name, " cov_valid_width"}, int'(cov_valid), 0);
        tick();
        tick();
        chk({v.name, " C_hold"}, int'(c_out[v.lane]), v.exp_c);
    endtask

    initial begin
        vec_t v;
        bit   stray;
        // name, lane, va, vb, gap, start_with_valid, start_at, expected mean
        vecs[0] = '{"x1x1_100",   0,    100,    100, 1'b0, 1'b0, -1,    100};
        vecs[1] = '{"x1x2_gap",   1,     -3,     -3, 1'b1, 1'b0, -1,     -3};
        vecs[2] = '{"x2x2_half",  4,      1,      0, 1'b0, 1'b0, -1,      0};
        vecs[3] = '{"x3x4_floor", 8,     -1,      0, 1'b0, 1'b0, -1,     -1};
        vecs[4] = '{"x4x4_max",   9,  32767,  32767, 1'b0, 1'b0, -1,  32767};
        vecs[5] = '{"x1x3_min",   2, -32768, -32768, 1'b0, 1'b0, -1, -32768};
        vecs[6] = '{"start_ign",  5,      2,      2, 1'b1, 1'b1, 30,      2};

        clear_prods();
        #12;
        // Reset state.
        chk("rst busy", int'(busy), 0);
        chk("rst cov_valid", int'(cov_valid), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("rst C[%0d]", k), int'(c_out[k]), 0);
        rst = 1'b0;
        tick();

        // In IDLE, in_valid without start must not start a frame or produce output.
        in_valid = 1'b1;
        prod[0]  = 16'sd5;
        tick();
        chk("idle_in_valid busy", int'(busy), 0);
        in_valid = 1'b0;
        clear_prods();
        tick();

        for (int t = 0; t < 7; t++) run_frame(vecs[t]);

        // Mid-frame reset: 50 samples, then asynchronous reset between edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            prod[3]  = 16'sd9;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst cov_valid", int'(cov_valid), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("midrst C[%0d]", k), int'(c_out[k]), 0);
        #1;
        rst = 1'b0;
        // Keep feeding samples without start: the discarded frame must not complete.
        stray = 1'b0;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (cov_valid || busy) stray = 1'b1;
        end
        chk("midrst no_output_without_start", int'(stray), 0);
        in_valid = 1'b0;
        clear_prods();
        tick();

        v = '{"restart_x1x4", 3, 7, 7, 1'b0, 1'b0, -1, 7};
        run_frame(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cov_accum.md
COV_ACCUM -- requirements
Module: cov_accum

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 128: samples per covariance frame; a power of two.
REQ-002 SHALL have parameter LOG2N, default 7: log2(N_SAMPLES), used as the divide shift.
REQ-003 SHALL have parameter DW, default 16: product input and covariance output width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1: frame start pulse, honoured only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: the ten product inputs carry a valid sample this cycle.
REQ-008 SHALL have ports X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4, each input, DW, signed: products from the whitening multiplier stage.
REQ-009 SHALL have ports C11, C12, C13, C14, C22, C23, C24, C33, C34, C44, each output, DW, signed: covariance estimates (upper triangle).
REQ-010 SHALL have port busy, output, 1: high when the state is ACCUM or DONE.
REQ-011 SHALL have port cov_valid, output, 1: one-cycle pulse marking new C outputs.

Function
REQ-012 SHALL use a 3-state FSM: IDLE, ACCUM, DONE.
REQ-013 In IDLE, start=1 SHALL clear all ten accumulators and the sample counter, then enter ACCUM; in_valid in IDLE SHALL be ignored, including when it coincides with start.
REQ-014 In ACCUM, each in_valid=1 cycle SHALL add every product to its own signed accumulator of DW+LOG2N bits (sign-extended) and increment the counter; in_valid=0 cycles SHALL hold all state.
REQ-015 The counter SHALL be LOG2N+1 bits; the cycle accepting sample N_SAMPLES SHALL move the FSM to DONE.
REQ-016 start SHALL be ignored in ACCUM and DONE.
REQ-017 In DONE, for one cycle, each C output SHALL be loaded with its accumulator arithmetic-shifted right by LOG2N (floor toward -inf), taking the low DW bits; the FSM SHALL then return to IDLE.
REQ-018 cov_valid SHALL be high exactly in the cycle after DONE, i.e. 2 cycles after the cycle that accepts the last sample.
REQ-019 C outputs SHALL hold their values until the next DONE.
REQ-020 in_valid during DONE SHALL be ignored.
REQ-021 No overflow is possible: the accumulator width is sufficient for N_SAMPLES full-scale samples, and the shifted result always fits in DW bits.

Reset
REQ-022 rst=1 SHALL asynchronously force: state IDLE, counter 0, all accumulators 0, all C outputs 0, cov_valid 0, busy 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; no cov_valid SHALL follow until a new start completes a full frame.

Structure
REQ-024 A shared whitening package SHALL hold N_SAMPLES, LOG2N, DW and the FSM state encoding.
REQ-025 One sub-module, cov_acc_lane (one accumulator with clear, add-enable and shift output), SHALL be instantiated ten times.

Verification
REQ-026 Bench SHALL cover: start, then 128 contiguous samples with X1X1=100 and all other inputs 0 -> cov_valid 2 cycles after the last sample, C11=100, all other C outputs 0.
REQ-027 Bench SHALL cover: X1X2=-3 for 128 samples, with in_valid deasserted for 1 cycle after every 10th sample -> C12=-3; cov_valid pulse width 1; busy high throughout.
REQ-028 Bench SHALL cover: X2X2=1 for 64 samples then 0 for 64 -> C22=0; and X3X4=-1 for 64 samples then 0 for 64 -> C34=-1 (floor).
REQ-029 Bench SHALL cover: X4X4=32767 for all 128 samples -> C44=32767; and X1X3=-32768 for all 128 samples -> C13=-32768.
REQ-030 Bench SHALL cover: rst asserted after 50 samples -> all outputs 0 immediately; restart with 128 samples of X1X4=7 -> C14=7.
REQ-031 Bench SHALL cover: start pulsed during ACCUM, and start coinciding with in_valid in IDLE -> the start is ignored, that sample is excluded, and the frame still ends at sample 128.
